// File: rtl/dpn_pipe_stage1.sv
// rtl/dpn_pipe_stage1.sv - first stage of the multi-precision N-lane dot-product unit
//
// Decodes FP16 / BF16 / FP32 operand pairs on every lane, forms the exact
// mantissa products, product signs, the maximum product exponent over the
// non-zero lanes and each lane's right-shift to that maximum. Results are
// captured in a main register backed by one skid entry (strict FIFO order).
//
// Optional build macro: SHIFT_SAT_EN - clamp each out_shift at 2*MAN_W+2.
//
// Ports:
//   gclk, reset          clock; asynchronous active-high reset
//   in_valid/in_ready    input handshake (in_ready is registered, = !skid_full)
//   in_mode              00=FP16, 01=FP32, 10=BF16, 11=FP32
//   in_a, in_b           operands, lane i at [32i+31:32i]
//   out_valid/out_ready  output handshake
//   out_mode             format of the presented beat
//   out_prod             unsigned mantissa products, lane i at [2*MAN_W*i +: 2*MAN_W]
//   out_sign, out_zero   per-lane product sign and zero flag
//   out_exp_max          signed maximum product exponent (0 when all lanes zero)
//   out_shift            per-lane unsigned alignment shift
//   out_all_zero         every lane is zero
module dpn_pipe_stage1 #(
   parameter int LANES = 4,
   parameter int MAN_W = 24,
   parameter int EXP_W = 10
) (
   input  logic                     gclk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_mode,
   input  logic [32*LANES-1:0]      in_a,
   input  logic [32*LANES-1:0]      in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               out_mode,
   output logic [2*MAN_W*LANES-1:0] out_prod,
   output logic [LANES-1:0]         out_sign,
   output logic [LANES-1:0]         out_zero,
   output logic [EXP_W-1:0]         out_exp_max,
   output logic [EXP_W*LANES-1:0]   out_shift,
   output logic                     out_all_zero
);

   localparam int FRAC_W = MAN_W - 1;
   localparam int PROD_W = 2 * MAN_W;
   localparam int NODES  = 2 * LANES - 1;
   localparam int PAY_W  = 2 + PROD_W * LANES + 2 * LANES + EXP_W + EXP_W * LANES + 1;

   typedef struct packed {
      logic              sign;
      logic [7:0]        exp;
      logic [FRAC_W-1:0] frac;
   } op_t;

   // Narrow formats are widened to the FP32 field layout: exponent
   // zero-extended to 8 bits, fraction left-aligned into FRAC_W bits.
   function automatic op_t decode_op(input logic [1:0] mode, input logic [31:0] w);
      op_t r;
      case (mode)
         2'b00: begin
            r.sign = w[15];
            r.exp  = {3'b000, w[14:10]};
            r.frac = {w[9:0], {(FRAC_W - 10){1'b0}}};
         end
         2'b10: begin
            r.sign = w[15];
            r.exp  = w[14:7];
            r.frac = {w[6:0], {(FRAC_W - 7){1'b0}}};
         end
         default: begin
            r.sign = w[31];
            r.exp  = w[30:23];
            r.frac = w[22:0];
         end
      endcase
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Per-lane decode, sign, zero detect, exponent and exact product
   // ------------------------------------------------------------------
   op_t                     op_a     [LANES];
   op_t                     op_b     [LANES];
   logic signed [EXP_W-1:0] lane_exp [LANES];
   logic [LANES-1:0]        lane_sign;
   logic [LANES-1:0]        lane_zero;
   logic [PROD_W*LANES-1:0] prod_flat;
   logic [EXP_W-1:0]        bias;

   always_comb begin
      bias      = (in_mode == 2'b00) ? EXP_W'(15) : EXP_W'(127);
      lane_sign = '0;
      lane_zero = '0;
      prod_flat = '0;
      for (int i = 0; i < LANES; i++) begin
         op_a[i]      = decode_op(in_mode, in_a[32*i +: 32]);
         op_b[i]      = decode_op(in_mode, in_b[32*i +: 32]);
         lane_sign[i] = op_a[i].sign ^ op_b[i].sign;
         // Exponent field 0 covers both true zero and subnormals (flushed).
         lane_zero[i] = (op_a[i].exp == 8'd0) || (op_b[i].exp == 8'd0);
         // EXP_W is wide enough for -125..381, so two's complement never wraps.
         lane_exp[i]  = EXP_W'(op_a[i].exp) + EXP_W'(op_b[i].exp) - bias;
         if (!lane_zero[i]) begin
            prod_flat[PROD_W*i +: PROD_W] = PROD_W'({1'b1, op_a[i].frac})
                                          * PROD_W'({1'b1, op_b[i].frac});
         end
      end
   end

   // ------------------------------------------------------------------
   // Max-exponent comparator tree, heap layout: leaves at LANES-1..NODES-1,
   // children of node n at 2n+1 / 2n+2. A node is valid if any non-zero lane
   // lies beneath it, so zero lanes never win.
   // ------------------------------------------------------------------
   logic signed [EXP_W-1:0] node_exp [NODES];
   logic                    node_vld [NODES];

   always_comb begin
      for (int n = 0; n < NODES; n++) begin
         node_exp[n] = '0;
         node_vld[n] = 1'b0;
      end
      for (int i = 0; i < LANES; i++) begin
         node_exp[LANES-1+i] = lane_exp[i];
         node_vld[LANES-1+i] = !lane_zero[i];
      end
      for (int n = LANES - 2; n >= 0; n--) begin
         if (node_vld[2*n+1] && node_vld[2*n+2]) begin
            node_exp[n] = (node_exp[2*n+1] > node_exp[2*n+2]) ? node_exp[2*n+1] : node_exp[2*n+2];
         end else if (node_vld[2*n+1]) begin
            node_exp[n] = node_exp[2*n+1];
         end else begin
            node_exp[n] = node_exp[2*n+2];
         end
         node_vld[n] = node_vld[2*n+1] | node_vld[2*n+2];
      end
   end

   // ------------------------------------------------------------------
   // Alignment shifts
   // ------------------------------------------------------------------
`ifdef SHIFT_SAT_EN
   // Lanes shifted further than this are fully lost downstream anyway.
   localparam logic [EXP_W-1:0] SHIFT_SAT = EXP_W'(2 * MAN_W + 2);
`endif

   logic signed [EXP_W-1:0] exp_max;
   logic                    all_zero;
   logic [EXP_W-1:0]        shift_diff [LANES];
   logic [EXP_W*LANES-1:0]  shift_flat;

   always_comb begin
      exp_max    = node_vld[0] ? node_exp[0] : '0;
      all_zero   = !node_vld[0];
      shift_flat = '0;
      for (int i = 0; i < LANES; i++) begin
         shift_diff[i] = '0;
         if (!lane_zero[i]) begin
            // exp_max >= lane_exp for every non-zero lane: never negative.
            shift_diff[i] = exp_max - lane_exp[i];
`ifdef SHIFT_SAT_EN
            if (shift_diff[i] > SHIFT_SAT) begin
               shift_diff[i] = SHIFT_SAT;
            end
`endif
         end
         shift_flat[EXP_W*i +: EXP_W] = shift_diff[i];
      end
   end

   logic [PAY_W-1:0] pay_in;
   assign pay_in = {in_mode, prod_flat, lane_sign, lane_zero, exp_max, shift_flat, all_zero};

   // ------------------------------------------------------------------
   // Main register + skid entry
   // ------------------------------------------------------------------
   logic [PAY_W-1:0] main_q;
   logic [PAY_W-1:0] skid_q;
   logic             main_vld;
   logic             skid_vld;
   logic             rdy_q;
   logic             accept;
   logic             drain;
   logic             main_vld_d;
   logic             skid_vld_d;
   logic             load_main_in;
   logic             load_main_skid;
   logic             load_skid;

   assign accept = in_valid && rdy_q;
   assign drain  = main_vld && out_ready;

   always_comb begin
      main_vld_d     = main_vld;
      skid_vld_d     = skid_vld;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (!main_vld || drain) begin
         if (skid_vld) begin
            // Oldest beat moves forward; a new beat queues behind it.
            load_main_skid = 1'b1;
            main_vld_d     = 1'b1;
            load_skid      = accept;
            skid_vld_d     = accept;
         end else begin
            load_main_in = accept;
            main_vld_d   = accept;
         end
      end else if (accept) begin
         // Downstream stalled: park the beat in the skid entry.
         load_skid  = 1'b1;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge gclk or posedge reset) begin
      if (reset) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         main_vld <= main_vld_d;
         skid_vld <= skid_vld_d;
         rdy_q    <= !skid_vld_d;
         if (load_main_skid) begin
            main_q <= skid_q;
         end else if (load_main_in) begin
            main_q <= pay_in;
         end
         if (load_skid) begin
            skid_q <= pay_in;
         end
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = main_vld;
   assign {out_mode, out_prod, out_sign, out_zero, out_exp_max, out_shift, out_all_zero} = main_q;

endmodule

// File: doc/dpn_pipe_stage1.md
Name: dpn_pipe_stage1

Overview:
Parametrised first pipeline stage of the multi-precision N-lane dot-product unit. It is the successor to the fixed 4-lane stage and adds:
- configurable lane count;
- three formats: FP16, BF16 and FP32;
- zero-operand detection;
- a signed, non-wrapping exponent path;
- valid/ready flow control with a 2-entry skid buffer.

Per lane it produces the exact mantissa product, the product sign, the maximum product exponent and the per-lane alignment shift. All outputs feed the downstream alignment/adder-tree stage.

Parameters:
LANES, 4, number of product lanes (power of 2, 2..16)
MAN_W, 24, internal mantissa width including hidden bit (fixed by FP32)
EXP_W, 10, signed product-exponent width and unsigned shift width

Ports:
gclk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  stage can accept a beat this cycle
in_mode  input  2  00=FP16, 01=FP32, 10=BF16, 11=reserved (treated as FP32)
in_a  input  32*LANES  operand A; lane i at [32i+31:32i]
in_b  input  32*LANES  operand B; same packing
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_mode  output  2  in_mode of this beat
out_prod  output  2*MAN_W*LANES  unsigned mantissa products; lane i at [48i+47:48i]
out_sign  output  LANES  product signs
out_zero  output  LANES  lane product is zero
out_exp_max  output  EXP_W  signed maximum unbiased-plus-bias product exponent
out_shift  output  EXP_W*LANES  unsigned right-shift per lane
out_all_zero  output  1  every lane zero

Behaviour:
- Reset: clock gclk; reset is asynchronous and active-high. All registered state clears and every output resets to 0, including out_valid. in_ready is 0 while reset is asserted and 1 in the first cycle after release. A reset asserted mid-transfer discards both buffered beats.
- Field extraction, FP32: sign 31, exponent [30:23], mantissa [22:0], bias 127.
- Field extraction, FP16: sign 15, exponent [14:10], mantissa [9:0] left-aligned into 23 bits, bias 15.
- Field extraction, BF16: sign 15, exponent [14:7], mantissa [6:0] left-aligned, bias 127.
- Zero/subnormal: an operand with exponent field 0 is flushed to zero. Its lane has out_zero=1, out_prod=0, sign still XORed, and it is excluded from the max.
- Product: out_prod = {1,manA} * {1,manB}, exact 48-bit. A Dadda carry-save tree plus final adder is allowed.
- Sign: out_sign = signA ^ signB.
- Lane exponent: expA + expB - bias, computed in EXP_W signed arithmetic with no wrap. FP32 range is -125..381.
- out_exp_max: maximum lane exponent over non-zero lanes. Ties are harmless. If all lanes are zero, out_exp_max=0 and out_all_zero=1.
- Shift: out_shift[i] = exp_max - exp_i for non-zero lanes, always >= 0. Zero lanes get shift 0.
- Max tree: comparator tree of depth log2(LANES); no enumerated-case table.
- Latency: 1 cycle. A beat accepted at edge n is presented at edge n+1 with out_valid=1, provided the output register is empty or draining.
- Handshake, input: a transfer occurs when in_valid && in_ready.
- Handshake, output: a transfer occurs when out_valid && out_ready.
- Output stability: while out_valid=1 and out_ready=0, all out_* signals hold stable.
- Skid buffer: main register plus one skid entry, in strict FIFO order.
- in_ready = !skid_full. It is registered, so one beat can be absorbed after downstream stalls.
- Simultaneous accept and drain with the skid full: skid moves to main, the new beat moves to skid, and in_ready stays 0 that cycle.
- Simultaneous accept and drain with the skid empty: the new beat goes straight to main.
- Idle/bubble cycles: no state change except out_valid deasserting on drain.
- Mode: in_mode is sampled per beat. Mixed-format beats may be back-to-back with no bubble.

Optional Feature:
SHIFT_SAT_EN
- Defined: each out_shift saturates at 2*MAN_W+2 = 50. Any larger difference outputs 50, because such a lane is fully shifted out downstream. This allows narrower downstream shifters.
- Undefined: out_shift carries the full EXP_W-bit difference, up to 506.

Test Plan:
- FP32, LANES=4: A={1.0,2.0,1.0,0.5}, B={1.0,2.0,1.0,1.0} (0x3F800000, 0x40000000, 0x3F000000) -> exp_max=129, shifts {2,0,2,3}, prod lane0=0x400000000000, out_zero=0.
- FP16: lane0 0x3C00*0x4000, lane1 0xBC00*0x3C00, others 0x0000 -> exp_max=16, shifts {0,1,0,0}, signs {0,1,x,x}, out_zero=4'b1100.
- BF16 0x3F80*0x3F80 on all lanes -> exp_max=127, all shifts 0. Then FP32 exponent fields 1*1 on lane0 and 254*254 on lane1 -> exp_max=381, lane0 shift 506 (50 with SHIFT_SAT_EN).
- Backpressure: stream 6 beats, hold out_ready=0 for 4 cycles after beat 1 -> in_ready drops after the 2nd buffered beat. No loss or reordering; outputs stay stable while stalled.
- Continuous in_valid=out_ready=1 with alternating FP16/FP32 beats -> one output per cycle, 1-cycle latency, correct out_mode per beat.
- Assert reset with 2 beats buffered -> out_valid=0 immediately. in_ready=1 after release; the next beat emerges with 1-cycle latency.
